// File: rtl/apb_requester_if.sv
// Command/response channel plus APB bus between the tile requester and its peers.
// master: the requester's view; slave: the command source, response sink and APB completer.
interface apb_requester_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  busy;

    logic                  psel;
    logic                  penable;
    logic [2:0]            pprot;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        input  pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output psel, penable, pprot, paddr, pwrite, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        output pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  psel, penable, pprot, paddr, pwrite, pwdata, pstrb
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB initiator: command in, SETUP/ACCESS transfer, response out.
// An ACCESS-phase watchdog aborts transfers to a completer that never asserts pready.
module apb_requester #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    apb_requester_if.master      bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_wd_cnt;

    logic w_accept;
    logic w_done;
    logic w_expire;

    assign w_accept = bus.cmd_valid && (r_state == StIdle);
    assign w_done   = (r_state == StAccess) && bus.pready;
    // pready on the final watchdog cycle still completes normally
    assign w_expire = (TIMEOUT != 0) && (r_state == StAccess) && !bus.pready &&
                      (r_wd_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = StSetup;
            StSetup:  w_state_next = StAccess;
            StAccess: if (w_done || w_expire) w_state_next = StResp;
            StResp:   if (bus.rsp_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.cmd_ready   = (r_state == StIdle);
        bus.busy        = (r_state != StIdle);
        bus.psel        = (r_state == StSetup) || (r_state == StAccess);
        bus.penable     = (r_state == StAccess);
        bus.rsp_valid   = (r_state == StResp);
        bus.pprot       = PROT;
        bus.paddr       = r_addr;
        bus.pwrite      = r_write;
        bus.pwdata      = r_wdata;
        bus.pstrb       = r_strb;
        bus.rsp_rdata   = r_rdata;
        bus.rsp_err     = r_err;
        bus.rsp_timeout = r_timeout;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_wd_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_write <= bus.cmd_write;
                r_wdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                r_strb  <= bus.cmd_write ? bus.cmd_strb : '0;
            end

            if (r_state == StSetup) begin
                r_wd_cnt <= CNT_W'(1);
            end else if ((r_state == StAccess) && !w_done && !w_expire) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end

            if (w_done) begin
                r_rdata   <= (!r_write && !bus.pslverr) ? bus.prdata : '0;
                r_err     <= bus.pslverr;
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_rdata   <= '0;
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// Table-driven and randomized transaction checks for apb_requester with a transaction-level model.
module tb_apb_requester;
    localparam int unsigned TO   = 4;
    localparam logic [2:0]  PR   = 3'b101;
    localparam int          NTAB = 8;
    localparam int          NRND = 30;
    localparam int          N    = NTAB + NRND;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int unsigned waits;
        logic        err;
        logic [31:0] prdata;
        int unsigned bp;
        bit          b2b;
        int unsigned exp_acc;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } txn_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    txn_t list[N];

    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .PROT(PR)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic txn_t mk(logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                                int unsigned wt, logic e, logic [31:0] pd, int unsigned bp,
                                bit b2b, int unsigned acc, logic ee, logic et,
                                logic [31:0] er);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.waits = wt; t.err = e;
        t.prdata = pd; t.bp = bp; t.b2b = b2b; t.exp_acc = acc; t.exp_err = ee;
        t.exp_to = et; t.exp_rdata = er;
        return t;
    endfunction

    // Transaction-level expectation: the completer stalls for 'waits' cycles.
    function automatic txn_t model(txn_t t);
        txn_t r = t;
        bit timed = (t.waits >= TO);
        r.exp_acc   = timed ? TO : t.waits + 1;
        r.exp_err   = timed | t.err;
        r.exp_to    = timed;
        r.exp_rdata = (!timed && !t.write && !t.err) ? t.prdata : 32'h0;
        return r;
    endfunction

    task automatic drive_cmd(input txn_t t);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = t.write;
        bus.cmd_addr  = t.addr;
        bus.cmd_wdata = t.wdata;
        bus.cmd_strb  = t.strb;
    endtask

    task automatic scramble_cmd();
        bus.cmd_valid = 1'($urandom());
        bus.cmd_write = 1'($urandom());
        bus.cmd_addr  = $urandom();
        bus.cmd_wdata = $urandom();
        bus.cmd_strb  = 4'($urandom());
    endtask

    task automatic check_bus(input txn_t t, input logic en);
        chk("psel", bus.psel, 1'b1);
        chk("penable", bus.penable, en);
        chk("paddr", bus.paddr, t.addr);
        chk("pwrite", bus.pwrite, t.write);
        chk("pwdata", bus.pwdata, t.write ? t.wdata : 32'h0);
        chk("pstrb", bus.pstrb, t.write ? t.strb : 4'h0);
        chk("busy", bus.busy, 1'b1);
        chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
        chk("rsp_valid_busy", bus.rsp_valid, 1'b0);
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic run_txn(input txn_t t, input txn_t nx);
        logic pr;
        drive_cmd(t);
        bus.rsp_ready = 1'($urandom());
        bus.pready    = 1'($urandom());
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        scramble_cmd();
        check_bus(t, 1'b0);
        bus.pready = 1'($urandom());
        @(posedge clk); @(negedge clk);
        for (int n = 1; n <= int'(t.exp_acc); n++) begin
            check_bus(t, 1'b1);
            pr = (n == int'(t.waits) + 1);
            bus.pready  = pr;
            bus.prdata  = pr ? t.prdata : $urandom();
            bus.pslverr = pr ? t.err : 1'($urandom());
            @(posedge clk); @(negedge clk);
        end
        bus.pready = 1'b0;
        bus.rsp_ready = 1'b0;
        if (t.b2b) drive_cmd(nx);
        else bus.cmd_valid = 1'b0;
        for (int k = 0; k <= int'(t.bp); k++) begin
            if (k > 0) begin
                @(posedge clk); @(negedge clk);
            end
            chk("psel_resp", bus.psel, 1'b0);
            chk("penable_resp", bus.penable, 1'b0);
            chk("rsp_valid", bus.rsp_valid, 1'b1);
            chk("rsp_err", bus.rsp_err, t.exp_err);
            chk("rsp_timeout", bus.rsp_timeout, t.exp_to);
            chk("rsp_rdata", bus.rsp_rdata, t.exp_rdata);
            chk("cmd_ready_resp", bus.cmd_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
        chk("busy_idle", bus.busy, 1'b0);
        chk("cmd_ready_back", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        txn_t fresh;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.cmd_strb = '0; bus.rsp_ready = 1'b0; bus.pready = 1'b0; bus.prdata = '0;
        bus.pslverr = 1'b0;

        #2;
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwrite", bus.pwrite, 1'b0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_pstrb", bus.pstrb, 4'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pprot", bus.pprot, PR);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

        //        w  addr       wdata         strb  wt e  prdata        bp b2b acc ee et rdata
        list[0] = mk(1, 32'h4,  32'hA5,       4'h1, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0);
        list[1] = mk(0, 32'h8,  32'h0,        4'hF, 3, 0, 32'h5A,       0, 0, 4, 0, 0, 32'h5A);
        list[2] = mk(0, 32'hC,  32'h0,        4'h0, 0, 1, 32'hDEAD,     0, 0, 1, 1, 0, 32'h0);
        list[3] = mk(0, 32'h10, 32'h0,        4'h0, 9, 0, 32'h0,        0, 0, 4, 1, 1, 32'h0);
        list[4] = mk(0, 32'h14, 32'h0,        4'h0, 3, 0, 32'h77,       0, 0, 4, 0, 0, 32'h77);
        list[5] = mk(1, 32'h18, 32'h1234,     4'h3, 4, 0, 32'h0,        0, 0, 4, 1, 1, 32'h0);
        list[6] = mk(1, 32'h1C, 32'hCAFE,     4'hF, 2, 1, 32'h0,        5, 1, 3, 1, 0, 32'h0);
        list[7] = mk(0, 32'h13, 32'h0,        4'h0, 1, 0, 32'h12345678, 0, 0, 2, 0, 0,
                     32'h12345678);
        for (int i = NTAB; i < N; i++) begin
            txn_t t;
            t.write  = 1'($urandom());
            t.addr   = $urandom();
            t.wdata  = $urandom();
            t.strb   = 4'($urandom());
            t.waits  = $urandom_range(0, 6);
            t.err    = ($urandom_range(0, 3) == 0);
            t.prdata = $urandom();
            t.bp     = $urandom_range(0, 3);
            t.b2b    = (i != N - 1) && 1'($urandom());
            list[i]  = model(t);
        end

        for (int i = 0; i < N; i++) begin
            run_txn(list[i], (i + 1 < N) ? list[i + 1] : list[i]);
        end

        // Asynchronous reset in the middle of ACCESS
        fresh = mk(0, 32'h24, 32'h0, 4'h0, 2, 0, 32'h0BADF00D, 1, 0, 3, 0, 0, 32'h0BADF00D);
        drive_cmd(fresh);
        @(posedge clk); @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.pready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_psel", bus.psel, 1'b1);
        chk("mid_penable", bus.penable, 1'b1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_psel", bus.psel, 1'b0);
        chk("arst_penable", bus.penable, 1'b0);
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_paddr", bus.paddr, 32'h0);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("arst_cmd_ready", bus.cmd_ready, 1'b1);
        run_txn(fresh, fresh);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
